// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: state and mode encodings,
// entry width and bit offsets of each field inside a packed trace entry.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_LINEAR   = 1'b0;
  localparam logic MODE_CIRCULAR = 1'b1;

  // Entry layout, MSB first: {pc, ins, wr, wm, acc, addr, alu}
  function automatic int entry_w(input int pc_w, input int ins_w, input int data_w);
    return pc_w + ins_w + 2 + 3 * data_w;
  endfunction

  function automatic int off_alu(input int data_w);
    return 0 * data_w;
  endfunction

  function automatic int off_addr(input int data_w);
    return data_w;
  endfunction

  function automatic int off_acc(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_wm(input int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_wr(input int data_w);
    return 3 * data_w + 1;
  endfunction

  function automatic int off_ins(input int data_w);
    return 3 * data_w + 2;
  endfunction

  function automatic int off_pc(input int ins_w, input int data_w);
    return 3 * data_w + 2 + ins_w;
  endfunction

  // Offsets for the default configuration (PC_W=5, INS_W=8, DATA_W=8)
  localparam int DEF_ENTRY_W  = 39;
  localparam int DEF_OFF_ALU  = 0;
  localparam int DEF_OFF_ADDR = 8;
  localparam int DEF_OFF_ACC  = 16;
  localparam int DEF_OFF_WM   = 24;
  localparam int DEF_OFF_WR   = 25;
  localparam int DEF_OFF_INS  = 26;
  localparam int DEF_OFF_PC   = 34;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port storage for trace entries: one write port, one registered
// read port. The array itself is never reset so it maps onto block RAM.
module trace_ram #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace capture unit for the accumulator CPU: records qualified cycles in
// linear or circular mode around a trigger, then drains oldest-first.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int INS_W     = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int ENTRY_W  = entry_w(PC_W, INS_W, DATA_W),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               arm_i,
  input  logic               mode_i,
  input  logic               trig_i,
  input  logic               sample_en_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INS_W-1:0]   ins_i,
  input  logic               wr_i,
  input  logic               wm_i,
  input  logic [DATA_W-1:0]  acc_i,
  input  logic [DATA_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  alu_i,
  input  logic               rd_en_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [1:0]         state_o,
  output logic               done_o,
  output logic               wrapped_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TGT_LIN_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TGT_CIRC_C = CNT_W'(POST_TRIG);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
  logic             wrapped_q, wrapped_d;
  logic             rd_valid_q, rd_valid_d;
  logic             has_data_q, has_data_d;

  logic               ram_we;
  logic               ram_re;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] ram_rdata;
  logic [CNT_W-1:0]   post_tgt;
  logic               post_phase;
  logic               capture;

  assign wr_entry = {pc_i, ins_i, wr_i, wm_i, acc_i, addr_i, alu_i};

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_LINEAR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      has_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= rd_valid_d;
      has_data_q <= has_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    wrapped_d  = wrapped_q;
    rd_valid_d = 1'b0;
    has_data_d = has_data_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    post_tgt   = (mode_q == MODE_CIRCULAR) ? TGT_CIRC_C : TGT_LIN_C;
    // The trigger cycle already belongs to the post-trigger window.
    post_phase = (state_q == ST_POST) || ((state_q == ST_PRE) && trig_i);
    capture    = sample_en_i &&
                 (post_phase || ((state_q == ST_PRE) && (mode_q == MODE_CIRCULAR)));

    if (arm_i) begin
      state_d    = ST_PRE;
      mode_d     = mode_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      wrapped_d  = 1'b0;
    end else begin
      if (capture) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == FULL_C) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      if (post_phase) begin
        state_d = ST_POST;
        if (sample_en_i) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if ((post_cnt_q + 1'b1) == post_tgt) begin
            state_d = ST_DONE;
          end
        end
      end

      if ((state_q == ST_DONE) && rd_en_i && (count_q != '0)) begin
        ram_re     = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        count_d    = count_q - 1'b1;
        rd_valid_d = 1'b1;
        has_data_d = 1'b1;
      end
    end
  end

  trace_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset, so mask it until a read has happened.
  assign rd_data_o  = has_data_q ? ram_rdata : '0;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign state_o    = state_q;
  assign done_o     = (state_q == ST_DONE);
  assign wrapped_o  = wrapped_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: reads push expected entries into a
// scoreboard queue, a negedge monitor pops and compares on rd_valid_o.
module tb_cpu_trace_buffer;

  logic        clk;
  logic        reset_n;
  logic        arm_i, mode_i, trig_i, sample_en_i;
  logic [4:0]  pc_i;
  logic [7:0]  ins_i;
  logic        wr_i, wm_i;
  logic [7:0]  acc_i, addr_i, alu_i;
  logic        rd_en_i;
  logic [38:0] rd_data_o;
  logic        rd_valid_o;
  logic [4:0]  count_o;
  logic [1:0]  state_o;
  logic        done_o;
  logic        wrapped_o;

  int vectors = 0;
  int miscompares = 0;
  logic [38:0] sb[$];

  cpu_trace_buffer #(
    .PC_W(5), .INS_W(8), .DATA_W(8), .DEPTH(16), .POST_TRIG(4)
  ) dut (
    .clk_i(clk), .reset_n(reset_n), .arm_i(arm_i), .mode_i(mode_i),
    .trig_i(trig_i), .sample_en_i(sample_en_i), .pc_i(pc_i), .ins_i(ins_i),
    .wr_i(wr_i), .wm_i(wm_i), .acc_i(acc_i), .addr_i(addr_i), .alu_i(alu_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .count_o(count_o), .state_o(state_o), .done_o(done_o), .wrapped_o(wrapped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Per-pc field values so every entry field differs between samples.
  function automatic logic [7:0] f_ins(input logic [4:0] pc);
    return {pc, 3'b011} ^ 8'hA5;
  endfunction
  function automatic logic [7:0] f_acc(input logic [4:0] pc);
    return {3'b000, pc} + 8'h40;
  endfunction
  function automatic logic [7:0] f_addr(input logic [4:0] pc);
    return ~{3'b000, pc};
  endfunction
  function automatic logic [7:0] f_alu(input logic [4:0] pc);
    return {pc, 3'b000} | 8'h03;
  endfunction
  function automatic logic [38:0] mk_entry(input logic [4:0] pc);
    return {pc, f_ins(pc), pc[0], pc[1], f_acc(pc), f_addr(pc), f_alu(pc)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic sample(input int pc, input bit trig);
    pc_i        = 5'(pc);
    ins_i       = f_ins(5'(pc));
    wr_i        = pc_i[0];
    wm_i        = pc_i[1];
    acc_i       = f_acc(5'(pc));
    addr_i      = f_addr(5'(pc));
    alu_i       = f_alu(5'(pc));
    sample_en_i = 1'b1;
    trig_i      = trig;
    cyc();
    sample_en_i = 1'b0;
    trig_i      = 1'b0;
  endtask

  task automatic arm(input bit mode);
    arm_i  = 1'b1;
    mode_i = mode;
    cyc();
    arm_i  = 1'b0;
  endtask

  task automatic trig_only();
    trig_i = 1'b1;
    cyc();
    trig_i = 1'b0;
  endtask

  task automatic read_one(input bit exp_valid, input int pc);
    if (exp_valid) sb.push_back(mk_entry(5'(pc)));
    rd_en_i = 1'b1;
    cyc();
    rd_en_i = 1'b0;
    chk($sformatf("rd_valid pc%0d", pc), 64'(rd_valid_o), 64'(exp_valid));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && rd_valid_o) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected got=%h expected=none", rd_data_o);
      end else begin
        logic [38:0] exp;
        exp = sb.pop_front();
        if (rd_data_o !== exp) begin
          miscompares++;
          $display("FAIL rd_data got=%h expected=%h", rd_data_o, exp);
        end else begin
          $display("ok   rd_data pc=%0d entry=%h", rd_data_o[38:34], rd_data_o);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; arm_i = 0; mode_i = 0; trig_i = 0; sample_en_i = 0;
    pc_i = 0; ins_i = 0; wr_i = 0; wm_i = 0; acc_i = 0; addr_i = 0; alu_i = 0;
    rd_en_i = 0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    chk("reset state", 64'(state_o), 64'd0);
    chk("reset count", 64'(count_o), 64'd0);

    // Linear: pre-trigger samples dropped, trigger sample is first of 16
    arm(1'b0);
    for (int p = 0; p < 4; p++) sample(p, 1'b0);
    chk("lin pre count", 64'(count_o), 64'd0);
    sample(4, 1'b1);
    chk("lin trig state", 64'(state_o), 64'd2);
    chk("lin trig count", 64'(count_o), 64'd1);
    for (int p = 5; p < 19; p++) sample(p, 1'b0);
    chk("lin pc18 state", 64'(state_o), 64'd2);
    sample(19, 1'b0);
    chk("lin done state", 64'(state_o), 64'd3);
    chk("lin done_o", 64'(done_o), 64'd1);
    chk("lin count", 64'(count_o), 64'd16);
    chk("lin wrapped", 64'(wrapped_o), 64'd0);
    for (int p = 4; p < 20; p++) read_one(1'b1, p);
    read_one(1'b0, 99);
    chk("lin drained count", 64'(count_o), 64'd0);

    // Circular with wrap
    arm(1'b1);
    for (int p = 0; p < 20; p++) sample(p, 1'b0);
    chk("circ wrapped", 64'(wrapped_o), 64'd1);
    chk("circ full count", 64'(count_o), 64'd16);
    chk("circ pre state", 64'(state_o), 64'd1);
    sample(20, 1'b1);
    chk("circ trig state", 64'(state_o), 64'd2);
    for (int p = 21; p < 24; p++) sample(p, 1'b0);
    chk("circ done state", 64'(state_o), 64'd3);
    chk("circ count", 64'(count_o), 64'd16);
    for (int p = 8; p < 24; p++) read_one(1'b1, p);
    read_one(1'b0, 99);

    // Circular early trigger
    arm(1'b1);
    sample(0, 1'b0); sample(1, 1'b0);
    sample(2, 1'b1);
    for (int p = 3; p < 6; p++) sample(p, 1'b0);
    chk("early state", 64'(state_o), 64'd3);
    chk("early count", 64'(count_o), 64'd6);
    chk("early wrapped", 64'(wrapped_o), 64'd0);
    for (int p = 0; p < 6; p++) read_one(1'b1, p);

    // Trigger without sample, then trigger in POST ignored
    arm(1'b1);
    for (int p = 0; p < 3; p++) sample(p, 1'b0);
    trig_only();
    chk("t5 trig state", 64'(state_o), 64'd2);
    chk("t5 trig count", 64'(count_o), 64'd3);
    sample(3, 1'b1);
    sample(4, 1'b0); sample(5, 1'b0);
    chk("t5 post state", 64'(state_o), 64'd2);
    sample(6, 1'b0);
    chk("t5 done state", 64'(state_o), 64'd3);
    chk("t5 count", 64'(count_o), 64'd7);
    for (int p = 0; p < 7; p++) read_one(1'b1, p);

    // Arm with sample during POST drops the sample; reads in PRE ignored
    arm(1'b1);
    trig_only();
    sample(0, 1'b0);
    chk("t6 post count", 64'(count_o), 64'd1);
    sample_en_i = 1'b1;
    arm(1'b1);
    sample_en_i = 1'b0;
    chk("t6 arm state", 64'(state_o), 64'd1);
    chk("t6 arm count", 64'(count_o), 64'd0);
    read_one(1'b0, 99);
    chk("t6 pre count", 64'(count_o), 64'd0);

    // Asynchronous reset in POST with wrapped set and rd_data holding a value
    for (int p = 0; p < 18; p++) sample(p, 1'b0);
    trig_only();
    chk("rst pre-state", 64'(state_o), 64'd2);
    chk("rst pre-wrapped", 64'(wrapped_o), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async state", 64'(state_o), 64'd0);
    chk("async count", 64'(count_o), 64'd0);
    chk("async wrapped", 64'(wrapped_o), 64'd0);
    chk("async rd_valid", 64'(rd_valid_o), 64'd0);
    chk("async done", 64'(done_o), 64'd0);
    chk("async rd_data", 64'(rd_data_o), 64'd0);
    cyc();
    reset_n = 1'b1;
    sample(1, 1'b1);
    chk("idle state", 64'(state_o), 64'd0);
    chk("idle count", 64'(count_o), 64'd0);

    cyc();
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable trace capture unit for the accumulator CPU. It replaces fixed "print the first N cycles" logging with on-chip capture.
- Each qualified cycle, it records the CPU's observable state (PC, instruction, Wr/Wm strobes, accumulator, RAM address, ALU bus) into a DEPTH-entry buffer.
- Supports linear (trigger-then-capture) and circular (pre-trigger history plus post-trigger) modes.
- Drains oldest-first through a read port.
- Sits beside the cpu core and is fed from its debug outputs.

Parameters:
PC_W, 5, program counter width
INS_W, 8, instruction width
DATA_W, 8, width of accumulator, RAM address and ALU bus
DEPTH, 16, buffer entries; power of 2, at least 2
POST_TRIG, 4, circular mode: entries captured from trigger inclusive; 1..DEPTH

Ports:
clk_i  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
arm_i  in  1  clear buffer, latch mode_i, enter PRE
mode_i  in  1  0 = linear, 1 = circular; sampled only on arm_i
trig_i  in  1  trigger event
sample_en_i  in  1  capture qualifier (one per instruction)
pc_i  in  PC_W  current PC
ins_i  in  INS_W  current instruction
wr_i  in  1  accumulator write strobe
wm_i  in  1  memory write strobe
acc_i  in  DATA_W  accumulator value
addr_i  in  DATA_W  RAM address
alu_i  in  DATA_W  ALU bus
rd_en_i  in  1  pop oldest entry
rd_data_o  out  ENTRY_W  {pc, ins, wr, wm, acc, addr, alu}, pc at MSB; ENTRY_W = PC_W+INS_W+2+3*DATA_W
rd_valid_o  out  1  rd_data_o valid this cycle
count_o  out  $clog2(DEPTH)+1  stored entries
state_o  out  2  IDLE=0, PRE=1, POST=2, DONE=3
done_o  out  1  state_o == DONE
wrapped_o  out  1  circular mode overwrote at least one entry

Behaviour:
Reset:
- reset_n low asynchronously forces state IDLE and clears wr_ptr, rd_ptr, count, post_cnt and wrapped.
- All outputs go to 0 immediately, no clock edge needed.

Priority per cycle: reset_n > arm_i > trigger/sample logic > read.
- arm_i in any state: clears pointers, count, post_cnt and wrapped; latches mode; next state PRE.
- A sample or read in the arm cycle is discarded.

IDLE: nothing written; trig_i and rd_en_i ignored.

PRE, linear mode:
- No writes.
- trig_i moves to POST. If sample_en_i is also high that cycle, that sample is written and counts as the first POST entry.

PRE, circular mode:
- Each sample_en_i writes at wr_ptr; wr_ptr increments modulo DEPTH.
- When count == DEPTH: the oldest entry is overwritten, rd_ptr advances, count holds at DEPTH, wrapped sets.
- trig_i moves to POST; a sample in the trigger cycle is written and counts as post entry 1.

POST:
- Each sample_en_i writes and increments post_cnt; trig_i is ignored.
- Enter DONE on the cycle the final entry is written: post_cnt reaches DEPTH (linear) or POST_TRIG (circular).
- If the trigger-cycle sample alone satisfies the target (POST_TRIG = 1), go directly PRE to DONE.
- Circular mode keeps overwriting when full.

DONE:
- Writes blocked.
- rd_en_i with count > 0: read buffer at rd_ptr (synchronous read); rd_data_o and rd_valid_o appear the next cycle for exactly one cycle; rd_ptr increments modulo DEPTH; count decrements.
- rd_en_i with count == 0: ignored; rd_valid_o stays 0.
- rd_data_o holds its last value when rd_valid_o is 0.
- DONE persists until arm_i or reset.

rd_en_i outside DONE: ignored.

Decomposition:
- Package cpu_trace_pkg: state encoding constants, mode constants, ENTRY_W function, field offset constants for rd_data_o unpacking.
- One sub-module, trace_ram: simple dual-port DEPTH x ENTRY_W, one write port and one synchronous read port, no reset on the array.
- Top level holds the FSM, pointers and counters.

Test Plan (DEPTH=16, POST_TRIG=4):
1. Assert reset_n=0 during POST with no clock edge -> state_o=0, count_o=0, rd_valid_o=0, wrapped_o=0 immediately.
2. Linear: arm, samples pc 0..3 (not stored), trig with sample pc=4, then pc 5..19 -> DONE when pc 19 is written, count 16; 16 reads return pc 4..19, each one cycle after rd_en; 17th read gives rd_valid_o=0.
3. Circular wrap: arm, samples pc 0..19 (wrapped_o=1, count 16), trig+sample pc=20, then pc 21..23 -> DONE; reads return pc 8..23 in order.
4. Circular early trigger: arm, pc 0,1, trig+sample pc=2, pc 3..5 -> DONE, count 6, wrapped 0; reads return pc 0..5.
5. Trig without sample_en in PRE (circular) -> POST, no write; next 4 samples -> DONE; trig during POST has no effect.
6. arm_i with sample_en_i during POST -> state PRE, count 0, sample dropped; rd_en_i in PRE gives rd_valid_o=0.
